// File: rtl/rc1m_timebase.sv
// Timebase and reset sequencer on the 1 MHz RC oscillator clock: 1 ms / 1 s strobes,
// uptime seconds, heartbeat, stretched fabric reset and a tick-granular watchdog.
module rc1m_timebase #(
  parameter int unsigned CLK_FREQ_HZ    = 1000000,
  parameter int unsigned RST_HOLD_MS    = 10,
  parameter int unsigned WDT_TIMEOUT_MS = 1000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        WDT_EN,
  input  logic        WDT_KICK,
  output logic        FABRIC_RESETN,
  output logic        TICK_1MS,
  output logic        TICK_1S,
  output logic        HEARTBEAT,
  output logic [31:0] UPTIME_S,
  output logic        WDT_EXPIRED,
  output logic        WDT_RST_FLAG
);

  localparam int unsigned MS_DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  typedef enum logic {HOLD, RUN} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [MS_W-1:0]   r_ms_cnt;
  logic [9:0]        r_s_cnt;
  logic [15:0]       r_hold_cnt;
  logic [15:0]       r_wdt_cnt;
  logic              r_tick_1ms;
  logic              r_tick_1s;
  logic              r_heartbeat;
  logic [31:0]       r_uptime;
  logic              r_fabric_resetn;
  logic              r_wdt_expired;
  logic              r_wdt_flag;
  logic              w_ms_wrap;
  logic              w_s_wrap;
  logic              w_hold_done;
  logic              w_expire;

  assign w_ms_wrap   = (r_ms_cnt == MS_W'(MS_DIV - 1));
  assign w_s_wrap    = w_ms_wrap && (r_s_cnt == 10'd999);
  // Hold and watchdog count the registered tick, so expiry lands one edge after a prescaler wrap.
  assign w_hold_done = r_tick_1ms && (r_hold_cnt == 16'(RST_HOLD_MS - 1));
  assign w_expire    = (r_state == RUN) && r_tick_1ms && WDT_EN && !WDT_KICK &&
                       (r_wdt_cnt == 16'(WDT_TIMEOUT_MS - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HOLD: if (w_hold_done) w_next_state = RUN;
      RUN:  if (w_expire)    w_next_state = HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_ms_cnt    <= '0;
      r_s_cnt     <= '0;
      r_tick_1ms  <= 1'b0;
      r_tick_1s   <= 1'b0;
      r_heartbeat <= 1'b0;
      r_uptime    <= '0;
    end else begin
      r_ms_cnt   <= w_ms_wrap ? '0 : r_ms_cnt + 1'b1;
      r_tick_1ms <= w_ms_wrap;
      r_tick_1s  <= w_s_wrap;
      if (w_ms_wrap) begin
        r_s_cnt <= (r_s_cnt == 10'd999) ? '0 : r_s_cnt + 10'd1;
      end
      if (w_s_wrap) begin
        r_heartbeat <= ~r_heartbeat;
        r_uptime    <= r_uptime + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_hold_cnt      <= '0;
      r_wdt_cnt       <= '0;
      r_fabric_resetn <= 1'b0;
      r_wdt_expired   <= 1'b0;
      r_wdt_flag      <= 1'b0;
    end else begin
      if (r_state != HOLD) begin
        r_hold_cnt <= '0;
      end else if (r_tick_1ms) begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end
      if ((r_state != RUN) || !WDT_EN || WDT_KICK || w_expire) begin
        r_wdt_cnt <= '0;
      end else if (r_tick_1ms) begin
        r_wdt_cnt <= r_wdt_cnt + 16'd1;
      end
      r_fabric_resetn <= (w_next_state == RUN);
      r_wdt_expired   <= w_expire;
      r_wdt_flag      <= r_wdt_flag | w_expire;
    end
  end

  assign FABRIC_RESETN = r_fabric_resetn;
  assign TICK_1MS      = r_tick_1ms;
  assign TICK_1S       = r_tick_1s;
  assign HEARTBEAT     = r_heartbeat;
  assign UPTIME_S      = r_uptime;
  assign WDT_EXPIRED   = r_wdt_expired;
  assign WDT_RST_FLAG  = r_wdt_flag;

endmodule
